// File: rtl/common_pkg.sv
// =============================================================================
// Module : common (package)
// Brief  : Shared state encodings and default latencies for the control path.
// Rev    : 1.0 - initial memory-controller state enum and latency defaults
// =============================================================================
`default_nettype none

package common;

  localparam int c_MEM_ADDR_W = 16;
  localparam int c_RD_LAT     = 2;
  localparam int c_WR_LAT     = 1;

  typedef enum logic [1:0] {
    M_IDLE     = 2'd0,
    M_ACCESS   = 2'd1,
    M_COMPLETE = 2'd2
  } memStates;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// =============================================================================
// Module : mem_wait_counter
// Brief  : Loadable down-counter with zero flag used to time wait states.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_controller.sv
// =============================================================================
// Module : mem_controller
// Brief  : Single-outstanding request bridge from the control unit to a
//          word-addressed synchronous memory with programmable wait states.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_controller
  import common::*;
#(
  parameter int ADDR_W = c_MEM_ADDR_W,
  parameter int RD_LAT = c_RD_LAT,
  parameter int WR_LAT = c_WR_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Valid,
  input  logic              RW,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       data,
  output logic              fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int c_CNT_W = $clog2(max_int(RD_LAT, WR_LAT)) + 1;

  memStates            r_state;
  memStates            w_next_state;

  logic                w_accept;
  logic                w_done;
  logic                w_dec;
  logic                w_cnt_zero;
  logic                w_misaligned;
  logic [c_CNT_W-1:0]  w_load_val;
  logic                w_unused_addr_hi;

  logic                r_rw;
  logic                r_fault_path;
  logic                r_ready;
  logic [31:0]         r_data;
  logic                r_fault;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;

  // Upper address bits are deliberately dropped so accesses wrap on the memory size.
  assign w_unused_addr_hi = ^address[31:ADDR_W+2];
  assign w_misaligned     = |address[1:0];

  // A misaligned request loads zero so the fault completes after one ACCESS cycle.
  assign w_load_val = w_misaligned ? '0 :
                      (RW ? c_CNT_W'(RD_LAT - 1) : c_CNT_W'(WR_LAT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= M_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      M_IDLE:     if (Valid)      w_next_state = M_ACCESS;
      M_ACCESS:   if (w_cnt_zero) w_next_state = M_COMPLETE;
      M_COMPLETE: if (!Valid)     w_next_state = M_IDLE;
      default:                    w_next_state = M_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_dec    = 1'b0;
    case (r_state)
      M_IDLE:   w_accept = Valid;
      M_ACCESS: begin
        w_done = w_cnt_zero;
        w_dec  = !w_cnt_zero;
      end
      default: ;
    endcase
  end

  mem_wait_counter #(
    .WIDTH (c_CNT_W)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_value (w_load_val),
    .i_dec   (w_dec),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rw         <= 1'b0;
      r_fault_path <= 1'b0;
      r_ready      <= 1'b1;
      r_data       <= '0;
      r_fault      <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      if (w_accept) begin
        r_rw         <= RW;
        r_fault_path <= w_misaligned;
        r_ready      <= 1'b0;
        r_fault      <= 1'b0;
        if (!w_misaligned) begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= !RW;
          r_mem_addr  <= address[ADDR_W+1:2];
          r_mem_wdata <= wdata;
        end
      end
      if (w_done) begin
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
        r_ready  <= 1'b1;
        if (r_fault_path) begin
          r_fault <= 1'b1;
        end else if (r_rw) begin
          r_data <= mem_rdata;
        end
      end
    end
  end

  assign ready     = r_ready;
  assign data      = r_data;
  assign fault     = r_fault;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_controller.sv
// =============================================================================
// Module : tb_mem_controller
// Brief  : Directed self-checking bench for mem_controller with a queue scoreboard.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_controller;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              Valid;
  logic              RW;
  logic [31:0]       address;
  logic [31:0]       wdata;
  logic              ready;
  logic [31:0]       data;
  logic              fault;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  typedef struct {
    logic [31:0] data;
    logic        flt;
    int          low;
    int          en;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_controller #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Valid     (Valid),
    .RW        (RW),
    .address   (address),
    .wdata     (wdata),
    .ready     (ready),
    .data      (data),
    .fault     (fault),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous read-first memory: read data appears one edge after an enabled read cycle.
  initial begin
    mem_rdata = '0;
    mem[4]    = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= mem[mem_addr];
      if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request, pushes its expectation, waits (bounded) for ready and compares.
  task automatic run_req(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_flt,
                         input int exp_en, input logic [31:0] exp_addr, input bit hold);
    exp_t        e;
    int          low;
    int          en;
    logic [31:0] sa;
    logic        swe;
    logic [31:0] swd;
    low = 0;
    en  = 0;
    sa  = '0;
    swe = 1'b0;
    swd = '0;
    e.data = exp_data;
    e.flt  = exp_flt;
    e.low  = exp_flt ? 1 : exp_en;
    e.en   = exp_en;
    e.addr = exp_addr;
    e.we   = !rw;
    e.wd   = wd;
    sb.push_back(e);
    Valid   = 1'b1;
    RW      = rw;
    address = a;
    wdata   = wd;
    tick();
    if (!hold) Valid = 1'b0;
    for (int k = 0; k < 20 && ready !== 1'b1; k++) begin
      low++;
      if (mem_en === 1'b1) begin
        en++;
        sa  = 32'(mem_addr);
        swe = mem_we;
        swd = mem_wdata;
      end
      tick();
    end
    e = sb.pop_front();
    chk("ready_back", 32'(ready), 32'd1);
    chk("ready_low_cycles", 32'(low), 32'(e.low));
    chk("mem_en_cycles", 32'(en), 32'(e.en));
    chk("data", data, e.data);
    chk("fault", 32'(fault), 32'(e.flt));
    if (e.en > 0) begin
      chk("mem_addr", sa, e.addr);
      chk("mem_we", 32'(swe), 32'(e.we));
      if (e.we) chk("mem_wdata", swd, e.wd);
    end
    if (!hold) tick();
  endtask

  initial begin
    int en_seen;
    int low_seen;
    reset   = 1'b0;
    Valid   = 1'b0;
    RW      = 1'b0;
    address = '0;
    wdata   = '0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_data", data, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Aligned read with two wait cycles, then single-cycle write leaving data alone.
    run_req(1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, RD_LAT, 32'd4, 1'b0);
    run_req(1'b0, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, WR_LAT, 32'd8, 1'b0);

    // Held Valid after completion must not start a second access.
    run_req(1'b1, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, RD_LAT, 32'd8, 1'b1);
    en_seen  = 0;
    low_seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (mem_en === 1'b1) en_seen++;
      if (ready !== 1'b1) low_seen++;
    end
    chk("held_valid_mem_en", 32'(en_seen), 32'd0);
    chk("held_valid_ready_low", 32'(low_seen), 32'd0);
    Valid = 1'b0;
    tick();
    run_req(1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, RD_LAT, 32'd4, 1'b0);

    // Misaligned read: fault, no memory cycle, data kept.
    run_req(1'b1, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 1'b1, 0, 32'd0, 1'b0);

    // Wrapping address; the next accepted request also clears fault.
    run_req(1'b0, 32'h0004_0008, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 1'b0, WR_LAT, 32'd2, 1'b0);
    run_req(1'b1, 32'h0000_0008, 32'h0, 32'hA5A5_5A5A, 1'b0, RD_LAT, 32'd2, 1'b0);

    // Reset during the second enable cycle of a read.
    Valid   = 1'b1;
    RW      = 1'b1;
    address = 32'h0000_0020;
    tick();
    Valid = 1'b0;
    tick();
    chk("pre_reset_mem_en", 32'(mem_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_mem_en", 32'(mem_en), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_data", data, 32'd0);
    chk("async_rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_req(1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, RD_LAT, 32'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
